// File: rtl/fwvexrisc_wb_arb_bridge.sv
// Arbitrates N simple-bus initiator ports onto a single Wishbone classic master
// and returns a one-cycle response strobe to the port that owned the transfer.
module fwvexrisc_wb_arb_bridge #(
    parameter int unsigned N_PORTS     = 2,
    parameter int unsigned ADR_WIDTH   = 32,
    parameter int unsigned ARB_MODE    = 0,
    parameter int unsigned TURN_CYCLES = 2,
    parameter int unsigned TIMEOUT     = 0
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [N_PORTS-1:0]             p_cmd_valid,
    output logic [N_PORTS-1:0]             p_cmd_ready,
    input  logic [N_PORTS-1:0]             p_cmd_wr,
    input  logic [N_PORTS*ADR_WIDTH-1:0]   p_cmd_adr,
    input  logic [N_PORTS*32-1:0]          p_cmd_dat,
    input  logic [N_PORTS*2-1:0]           p_cmd_size,
    output logic [N_PORTS-1:0]             p_rsp_valid,
    output logic [N_PORTS-1:0]             p_rsp_error,
    output logic [31:0]                    p_rsp_dat,
    output logic [ADR_WIDTH-1:0]           i_adr,
    output logic [31:0]                    i_dat_w,
    input  logic [31:0]                    i_dat_r,
    output logic                           i_cyc,
    output logic                           i_stb,
    output logic                           i_we,
    output logic [3:0]                     i_sel,
    input  logic                           i_ack,
    input  logic                           i_err
);

    localparam int unsigned IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    typedef enum logic [1:0] {StIdle, StBus, StRsp, StTurn} state_e;

    state_e                 r_state, w_state_nxt;
    logic [IDX_W-1:0]       r_owner, r_last, w_grant_idx, w_cand;
    logic                   w_grant_any, w_accept, w_term, w_tmo;
    logic [ADR_WIDTH-1:0]   w_g_adr, r_adr;
    logic [1:0]             w_g_size;
    logic [3:0]             w_sel, r_sel;
    logic [31:0]            r_dat_w, r_rsp_dat, r_cnt;
    logic [1:0]             r_turn;
    logic                   r_we, r_err;

    // Scan from lowest to highest priority so the winning candidate is written last.
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        w_cand      = '0;
        for (int k = int'(N_PORTS) - 1; k >= 0; k--) begin
            if (ARB_MODE == 0) begin
                w_cand = IDX_W'(k);
            end else begin
                w_cand = IDX_W'((int'(r_last) + 1 + k) % int'(N_PORTS));
            end
            if (p_cmd_valid[w_cand]) begin
                w_grant_any = 1'b1;
                w_grant_idx = w_cand;
            end
        end
    end

    assign w_g_adr  = p_cmd_adr[w_grant_idx*ADR_WIDTH +: ADR_WIDTH];
    assign w_g_size = p_cmd_size[w_grant_idx*2 +: 2];

    always_comb begin
        w_sel = 4'b1111;
        if (p_cmd_wr[w_grant_idx]) begin
            case (w_g_size)
                2'b01:   w_sel = w_g_adr[1] ? 4'b1100 : 4'b0011;
                2'b00:   w_sel = 4'b0001 << w_g_adr[1:0];
                default: w_sel = 4'b1111;
            endcase
        end
    end

    assign w_accept = (r_state == StIdle) && w_grant_any;
    assign w_term   = (r_state == StBus) && (i_ack || i_err);
    assign w_tmo    = (r_state == StBus) && !(i_ack || i_err) && (TIMEOUT != 0)
                      && (r_cnt == TIMEOUT - 1);

    always_comb begin
        p_cmd_ready = '0;
        if (w_accept && !reset) begin
            p_cmd_ready[w_grant_idx] = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle:  if (w_accept) w_state_nxt = StBus;
            StBus:   if (w_term || w_tmo) w_state_nxt = StRsp;
            StRsp:   w_state_nxt = (TURN_CYCLES == 0) ? StIdle : StTurn;
            StTurn:  if (r_turn == 2'(TURN_CYCLES - 1)) w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_adr     <= '0;
            r_dat_w   <= '0;
            r_we      <= 1'b0;
            r_sel     <= '0;
            r_owner   <= '0;
            r_last    <= IDX_W'(N_PORTS - 1);
            r_cnt     <= '0;
            r_turn    <= '0;
            r_err     <= 1'b0;
            r_rsp_dat <= '0;
        end else begin
            if (w_accept) begin
                r_adr   <= w_g_adr;
                r_dat_w <= p_cmd_dat[w_grant_idx*32 +: 32];
                r_we    <= p_cmd_wr[w_grant_idx];
                r_sel   <= w_sel;
                r_owner <= w_grant_idx;
                r_last  <= w_grant_idx;
                r_cnt   <= '0;
            end
            if (w_term) begin
                r_rsp_dat <= i_dat_r;
                r_err     <= i_err;
            end else if (w_tmo) begin
                r_rsp_dat <= '0;
                r_err     <= 1'b1;
            end else if (r_state == StBus) begin
                r_cnt <= r_cnt + 32'd1;
            end
            if (r_state == StRsp) begin
                r_turn <= '0;
            end else if (r_state == StTurn) begin
                r_turn <= r_turn + 2'd1;
            end
        end
    end

    always_comb begin
        p_rsp_valid = '0;
        p_rsp_error = '0;
        if (r_state == StRsp) begin
            p_rsp_valid[r_owner] = 1'b1;
            p_rsp_error[r_owner] = r_err;
        end
    end

    assign i_cyc     = (r_state == StBus);
    assign i_stb     = (r_state == StBus);
    assign i_adr     = r_adr;
    assign i_dat_w   = r_dat_w;
    assign i_we      = r_we;
    assign i_sel     = r_sel;
    assign p_rsp_dat = r_rsp_dat;

endmodule

// File: tb/tb_fwvexrisc_wb_arb_bridge.sv
// Scoreboard bench: dut0 is fixed-priority/TURN=2, dut1 is round-robin/TURN=1/TIMEOUT=4.
module tb_fwvexrisc_wb_arb_bridge;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {logic wr; logic [31:0] adr; logic [31:0] dat; logic [1:0] size;} cmd_t;
    typedef struct {logic [31:0] adr; logic we; logic [3:0] sel; logic [31:0] dat;} bus_t;
    typedef struct {int port; logic err; logic [31:0] dat;} rsp_t;

    logic        s_reset [2];
    logic [2:0]  s_valid [2], s_ready [2], s_wr [2], s_rv [2], s_re [2];
    logic [95:0] s_adr [2], s_dat [2];
    logic [5:0]  s_size [2];
    logic [31:0] s_rdat [2], s_wadr [2], s_wdat [2], s_dat_r [2];
    logic        s_cyc [2], s_stb [2], s_we [2], s_ack [2], s_err [2], force_ack [2];
    logic [3:0]  s_sel [2];

    cmd_t cmd_q [6][$];
    bus_t bus_q [2][$];
    rsp_t rsp_q [2][$];
    int   start_q [2][$];
    int   bus_len [2], cur_len [2], slv_wait [2], slv_mode [2], slv_cnt [2];
    logic cyc_prev [2];
    logic [2:0] acc [2];
    int   cyc_n, n_checks, n_errors;

    fwvexrisc_wb_arb_bridge #(.N_PORTS(3), .ADR_WIDTH(32), .ARB_MODE(0), .TURN_CYCLES(2),
                              .TIMEOUT(0)) u_dut_fix (
        .clock(clock), .reset(s_reset[0]), .p_cmd_valid(s_valid[0]), .p_cmd_ready(s_ready[0]),
        .p_cmd_wr(s_wr[0]), .p_cmd_adr(s_adr[0]), .p_cmd_dat(s_dat[0]), .p_cmd_size(s_size[0]),
        .p_rsp_valid(s_rv[0]), .p_rsp_error(s_re[0]), .p_rsp_dat(s_rdat[0]), .i_adr(s_wadr[0]),
        .i_dat_w(s_wdat[0]), .i_dat_r(s_dat_r[0]), .i_cyc(s_cyc[0]), .i_stb(s_stb[0]),
        .i_we(s_we[0]), .i_sel(s_sel[0]), .i_ack(s_ack[0]), .i_err(s_err[0])
    );

    fwvexrisc_wb_arb_bridge #(.N_PORTS(3), .ADR_WIDTH(32), .ARB_MODE(1), .TURN_CYCLES(1),
                              .TIMEOUT(4)) u_dut_rr (
        .clock(clock), .reset(s_reset[1]), .p_cmd_valid(s_valid[1]), .p_cmd_ready(s_ready[1]),
        .p_cmd_wr(s_wr[1]), .p_cmd_adr(s_adr[1]), .p_cmd_dat(s_dat[1]), .p_cmd_size(s_size[1]),
        .p_rsp_valid(s_rv[1]), .p_rsp_error(s_re[1]), .p_rsp_dat(s_rdat[1]), .i_adr(s_wadr[1]),
        .i_dat_w(s_wdat[1]), .i_dat_r(s_dat_r[1]), .i_cyc(s_cyc[1]), .i_stb(s_stb[1]),
        .i_we(s_we[1]), .i_sel(s_sel[1]), .i_ack(s_ack[1]), .i_err(s_err[1])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int d, input int p, input logic wr, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [1:0] size, input logic [3:0] sel,
                        input bit exp_rsp, input logic err, input logic [31:0] rdat);
        cmd_t c;
        bus_t b;
        rsp_t r;
        c.wr = wr; c.adr = adr; c.dat = dat; c.size = size;
        b.adr = adr; b.we = wr; b.sel = sel; b.dat = dat;
        r.port = p; r.err = err; r.dat = rdat;
        cmd_q[d*3+p].push_back(c);
        bus_q[d].push_back(b);
        if (exp_rsp) rsp_q[d].push_back(r);
    endtask

    // Negedge sampling: bus-cycle starts and response strobes are popped from the scoreboard.
    task automatic monitor();
        for (int d = 0; d < 2; d++) begin
            string t;
            t = $sformatf("dut%0d", d);
            if (s_cyc[d] && !cyc_prev[d]) begin
                start_q[d].push_back(cyc_n);
                cur_len[d] = 1;
                if (bus_q[d].size() == 0) begin
                    chk({t, "_bus_unexpected"}, 64'(s_wadr[d]), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    bus_t b;
                    b = bus_q[d].pop_front();
                    chk({t, "_bus_adr"}, 64'(s_wadr[d]), 64'(b.adr));
                    chk({t, "_bus_we"}, 64'(s_we[d]), 64'(b.we));
                    chk({t, "_bus_sel"}, 64'(s_sel[d]), 64'(b.sel));
                    chk({t, "_bus_dat_w"}, 64'(s_wdat[d]), 64'(b.dat));
                    chk({t, "_bus_stb"}, 64'(s_stb[d]), 64'd1);
                end
            end else if (s_cyc[d]) begin
                cur_len[d]++;
            end
            if (!s_cyc[d] && cyc_prev[d]) bus_len[d] = cur_len[d];
            cyc_prev[d] = s_cyc[d];
            if (s_rv[d] != 3'b000) begin
                if (rsp_q[d].size() == 0) begin
                    chk({t, "_rsp_unexpected"}, 64'(s_rv[d]), 64'd0);
                end else begin
                    rsp_t r;
                    logic [2:0] one;
                    r = rsp_q[d].pop_front();
                    one = 3'b001 << r.port;
                    chk({t, "_rsp_valid"}, 64'(s_rv[d]), 64'(one));
                    chk({t, "_rsp_error"}, 64'(s_re[d]), r.err ? 64'(one) : 64'd0);
                    chk({t, "_rsp_dat"}, 64'(s_rdat[d]), 64'(r.dat));
                end
            end
            acc[d] = s_valid[d] & s_ready[d];
        end
    endtask

    // Posedge+1 driving: refill accepted/idle ports from their queues, then model the slave.
    task automatic drive();
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 3; p++) begin
                if (acc[d][p] || !s_valid[d][p]) begin
                    if (cmd_q[d*3+p].size() > 0) begin
                        cmd_t c;
                        c = cmd_q[d*3+p].pop_front();
                        s_valid[d][p] = 1'b1;
                        s_wr[d][p] = c.wr;
                        s_adr[d][p*32 +: 32] = c.adr;
                        s_dat[d][p*32 +: 32] = c.dat;
                        s_size[d][p*2 +: 2] = c.size;
                    end else begin
                        s_valid[d][p] = 1'b0;
                    end
                end
            end
            acc[d] = '0;
            if (s_cyc[d]) slv_cnt[d]++;
            else slv_cnt[d] = 0;
            s_ack[d] = force_ack[d] ||
                       (s_cyc[d] && slv_mode[d] != 2 && slv_cnt[d] == slv_wait[d] + 1);
            s_err[d] = s_cyc[d] && slv_mode[d] == 1 && slv_cnt[d] == slv_wait[d] + 1;
        end
    endtask

    task automatic cycle();
        @(negedge clock);
        monitor();
        @(posedge clock);
        cyc_n++;
        #1;
        drive();
        #1;
    endtask

    function automatic bit pending(input int d);
        bit b;
        b = (s_valid[d] != 3'b000);
        for (int p = 0; p < 3; p++) if (cmd_q[d*3+p].size() > 0) b = 1'b1;
        return b;
    endfunction

    task automatic drain(input int d, input string tag);
        int n;
        n = 0;
        while ((rsp_q[d].size() != 0 || pending(d)) && n < 300) begin
            cycle();
            n++;
        end
        chk({tag, "_done"}, 64'(n < 300), 64'd1);
        repeat (4) cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc_n = 0;
        for (int d = 0; d < 2; d++) begin
            s_reset[d] = 1'b1; s_valid[d] = '0; s_wr[d] = '0; s_adr[d] = '0; s_dat[d] = '0;
            s_size[d] = '0; s_dat_r[d] = '0; s_ack[d] = 1'b0; s_err[d] = 1'b0;
            force_ack[d] = 1'b0; slv_wait[d] = 0; slv_mode[d] = 0; slv_cnt[d] = 0;
            cyc_prev[d] = 1'b0; acc[d] = '0; bus_len[d] = 0; cur_len[d] = 0;
        end
        repeat (3) cycle();
        s_valid[0] = 3'b111;
        s_valid[1] = 3'b111;
        cycle();
        chk("rst_ready0", 64'(s_ready[0]), 64'd0);
        chk("rst_ready1", 64'(s_ready[1]), 64'd0);
        chk("rst_cyc", 64'(s_cyc[0]), 64'd0);
        chk("rst_sel", 64'(s_sel[0]), 64'd0);
        chk("rst_adr", 64'(s_wadr[0]), 64'd0);
        chk("rst_rsp_dat", 64'(s_rdat[1]), 64'd0);
        chk("rst_rsp_valid", 64'(s_rv[1]), 64'd0);
        s_valid[0] = '0;
        s_valid[1] = '0;
        s_reset[0] = 1'b0;
        s_reset[1] = 1'b0;

        // Two simultaneous reads, one wait state: port 0 first, port 1 after the turnaround.
        slv_wait[0] = 1; slv_mode[0] = 0; s_dat_r[0] = 32'hCAFE_F00D;
        start_q[0].delete();
        push(0, 0, 1'b0, 32'h100, 32'h0, 2'b10, 4'b1111, 1'b1, 1'b0, 32'hCAFE_F00D);
        push(0, 1, 1'b0, 32'h200, 32'h0, 2'b10, 4'b1111, 1'b1, 1'b0, 32'hCAFE_F00D);
        drain(0, "fix_reads");
        chk("fix_reads_starts", 64'(start_q[0].size()), 64'd2);
        chk("fix_reads_gap", 64'(start_q[0][1] - start_q[0][0]), 64'd6);
        chk("fix_reads_len", 64'(bus_len[0]), 64'd2);

        // Byte/halfword/word lane selects, zero-wait slave, fixed priority under contention.
        slv_wait[0] = 0; s_dat_r[0] = 32'h1111_2222;
        start_q[0].delete();
        push(0, 0, 1'b1, 32'h13, 32'h0000_00AB, 2'b00, 4'b1000, 1'b1, 1'b0, 32'h1111_2222);
        push(0, 0, 1'b0, 32'h13, 32'h0000_0000, 2'b00, 4'b1111, 1'b1, 1'b0, 32'h1111_2222);
        push(0, 1, 1'b1, 32'h22, 32'h0000_BEEF, 2'b01, 4'b1100, 1'b1, 1'b0, 32'h1111_2222);
        push(0, 1, 1'b1, 32'h20, 32'h0000_1234, 2'b01, 4'b0011, 1'b1, 1'b0, 32'h1111_2222);
        push(0, 2, 1'b1, 32'h10, 32'h0000_0077, 2'b00, 4'b0001, 1'b1, 1'b0, 32'h1111_2222);
        push(0, 2, 1'b1, 32'h44, 32'h8765_4321, 2'b11, 4'b1111, 1'b1, 1'b0, 32'h1111_2222);
        drain(0, "fix_sel");
        chk("fix_sel_gap", 64'(start_q[0][1] - start_q[0][0]), 64'd5);

        // Error together with ack: error wins, data still latched; then stray acks in idle.
        slv_mode[0] = 1; s_dat_r[0] = 32'hDEAD_BEEF;
        push(0, 1, 1'b0, 32'h300, 32'h0, 2'b10, 4'b1111, 1'b1, 1'b1, 32'hDEAD_BEEF);
        drain(0, "fix_err");
        slv_mode[0] = 0; s_dat_r[0] = 32'h5555_5555; force_ack[0] = 1'b1;
        repeat (3) cycle();
        force_ack[0] = 1'b0;
        chk("idle_ack_cyc", 64'(s_cyc[0]), 64'd0);
        chk("idle_ack_hold", 64'(s_rdat[0]), 64'hDEAD_BEEF);

        // Reset during the second BUS cycle: cycle drops, no response, next command normal.
        slv_mode[0] = 2;
        push(0, 0, 1'b0, 32'h400, 32'h0, 2'b10, 4'b1111, 1'b0, 1'b0, 32'h0);
        begin
            int n;
            n = 0;
            while (!s_cyc[0] && n < 20) begin
                cycle();
                n++;
            end
        end
        chk("rst_bus_reached", 64'(s_cyc[0]), 64'd1);
        cycle();
        s_reset[0] = 1'b1;
        cycle();
        chk("rst_bus_cyc_drop", 64'(s_cyc[0]), 64'd0);
        chk("rst_bus_no_rsp", 64'(s_rv[0]), 64'd0);
        s_reset[0] = 1'b0; slv_mode[0] = 0; s_dat_r[0] = 32'h0BAD_F00D;
        repeat (3) cycle();
        push(0, 0, 1'b1, 32'h500, 32'h1212_1212, 2'b10, 4'b1111, 1'b1, 1'b0, 32'h0BAD_F00D);
        drain(0, "post_rst");

        // Round-robin with all three ports continuously valid: 0,1,2,0,1,2.
        slv_wait[1] = 0; slv_mode[1] = 0; s_dat_r[1] = 32'h1234_5678;
        start_q[1].delete();
        for (int i = 0; i < 2; i++) begin
            for (int p = 0; p < 3; p++) begin
                push(1, p, 1'b0, 32'h1000 * (p + 1) + 32'(4 * i), 32'h0, 2'b10, 4'b1111,
                     1'b1, 1'b0, 32'h1234_5678);
            end
        end
        drain(1, "rr_order");
        chk("rr_gap", 64'(start_q[1][1] - start_q[1][0]), 64'd4);

        // Slave never terminates: four BUS cycles, then error response with zero data.
        slv_mode[1] = 2; s_dat_r[1] = 32'hFFFF_FFFF;
        push(1, 2, 1'b0, 32'h7000, 32'h0, 2'b10, 4'b1111, 1'b1, 1'b1, 32'h0);
        drain(1, "tmo");
        chk("tmo_len", 64'(bus_len[1]), 64'd4);

        chk("dut0_bus_left", 64'(bus_q[0].size()), 64'd0);
        chk("dut1_bus_left", 64'(bus_q[1].size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fwvexrisc_wb_arb_bridge.md
FWVEXRISC_WB_ARB_BRIDGE -- requirements
Module: fwvexrisc_wb_arb_bridge

Interface
REQ-001 SHALL provide parameter N_PORTS, default 2: number of simple-bus initiator ports; range 1..8.
REQ-002 SHALL provide parameter ADR_WIDTH, default 32: command and Wishbone address width; data width is fixed at 32.
REQ-003 SHALL provide parameter ARB_MODE, default 0: 0 selects fixed priority (lowest index wins), 1 selects round-robin.
REQ-004 SHALL provide parameter TURN_CYCLES, default 2: idle cycles after each response; range 0..3.
REQ-005 SHALL provide parameter TIMEOUT, default 0: maximum cycles waiting for ack/err; 0 disables the timeout.
REQ-006 SHALL have the following ports, one per line:
  clock  in  1  sole clock, all logic on rising edge
  reset  in  1  synchronous, active-high reset
  p_cmd_valid  in  N_PORTS  per-port command valid
  p_cmd_ready  out  N_PORTS  per-port command accept
  p_cmd_wr  in  N_PORTS  per-port write flag
  p_cmd_adr  in  N_PORTS*ADR_WIDTH  packed addresses, port k at [k*ADR_WIDTH +: ADR_WIDTH]
  p_cmd_dat  in  N_PORTS*32  packed write data
  p_cmd_size  in  N_PORTS*2  packed size codes
  p_rsp_valid  out  N_PORTS  one-cycle response strobe
  p_rsp_error  out  N_PORTS  response error, qualified by p_rsp_valid
  p_rsp_dat  out  32  shared read data for all ports
  i_adr  out  ADR_WIDTH  Wishbone address
  i_dat_w  out  32  Wishbone write data
  i_dat_r  in  32  Wishbone read data
  i_cyc, i_stb, i_we  out  1 each  Wishbone cycle, strobe and write enable
  i_sel  out  4  Wishbone byte selects
  i_ack, i_err  in  1 each  Wishbone termination

Function
REQ-007 SHALL implement states IDLE, BUS, RSP and TURN.
REQ-008 In IDLE, p_cmd_ready SHALL assert combinationally for the granted port only; it SHALL be 0 in all other states.
REQ-009 ARB_MODE=0 SHALL grant the lowest-index valid port.
REQ-010 ARB_MODE=1 SHALL grant the first valid port searching from (last_grant+1) mod N_PORTS upward with wrap.
REQ-011 last_grant SHALL update only on acceptance and SHALL reset to N_PORTS-1, so port 0 has first priority.
REQ-012 On acceptance, the next cycle SHALL be BUS, with i_cyc=i_stb=1 and i_adr, i_dat_w, i_we registered from the granted port.
REQ-013 The granted index SHALL be held in an owner register.
REQ-014 i_sel SHALL be derived from size and adr[1:0]:
  size 10 or 11: 1111
  size 01: adr[1] ? 1100 : 0011
  size 00: one-hot 0001 shifted left by adr[1:0]
REQ-015 i_sel SHALL be 1111 for reads of every size.
REQ-016 Command fields SHALL NOT change while i_cyc=1.
REQ-017 In BUS, on i_ack or i_err, the bridge SHALL:
  deassert i_cyc and i_stb next cycle;
  latch i_dat_r into p_rsp_dat;
  move to RSP.
REQ-018 If i_ack and i_err are asserted in the same cycle, i_err SHALL win.
REQ-019 In RSP, p_rsp_valid[owner] SHALL be 1 for exactly one cycle, with p_rsp_error[owner] equal to the latched error.
REQ-020 From RSP, the next state SHALL be TURN, or IDLE when TURN_CYCLES=0.
REQ-021 Responses SHALL be issued for writes as well as reads.
REQ-022 TURN SHALL last TURN_CYCLES cycles, then go to IDLE.
REQ-023 Minimum period per transfer SHALL be 3+TURN_CYCLES cycles with a zero-wait-state slave.
REQ-024 With TIMEOUT>0, a counter SHALL clear on BUS entry and increment each BUS cycle.
REQ-025 When the counter reaches TIMEOUT with no termination, the bridge SHALL end the cycle and respond with error=1 and data 0.
REQ-026 i_ack or i_err arriving outside BUS SHALL be ignored.
REQ-027 p_rsp_dat SHALL hold its value until the next termination.
REQ-028 A port's p_cmd_valid deasserting before grant SHALL cause no transfer for that port.

Reset
REQ-029 While reset=1 at a clock edge, the bridge SHALL enter IDLE.
REQ-030 Reset SHALL clear i_cyc, i_stb, i_we, i_sel, i_adr, i_dat_w, p_rsp_valid, p_rsp_error, p_rsp_dat, the timeout counter and the owner register, and set last_grant to N_PORTS-1.
REQ-031 Reset asserted mid-BUS SHALL drop i_cyc at the next edge and SHALL produce no response.
REQ-032 p_cmd_ready SHALL be 0 while reset=1.

Verification
REQ-033 Fixed mode, ports 0 and 1 valid together, reads of 0x100 and 0x200, slave ack after 1 wait, dat 0xCAFEF00D -> port 0 served first with i_sel=1111 and p_rsp_dat=0xCAFEF00D; port 1 served after TURN.
REQ-034 Round-robin with N_PORTS=3, all ports valid continuously -> grant order 0,1,2,0.
REQ-035 Byte write at adr 0x13, data 0x000000AB -> i_sel=1000, i_we=1, p_rsp_valid pulse with error=0.
REQ-036 Halfword write at adr 0x22 -> i_sel=1100.
REQ-037 Slave asserts i_err together with i_ack -> p_rsp_error=1.
REQ-038 TIMEOUT=4 with a slave that never acks -> i_cyc drops after 4 BUS cycles, error=1, p_rsp_dat=0.
REQ-039 Reset pulsed in BUS cycle 2 -> i_cyc=0 next cycle, no p_rsp_valid, and the next command is granted normally.
